// File: rtl/cva6_ldbuf_pkg.sv
// Shared types and constants for the CVA6 load buffer.
// Entry field widths follow the default build (TRANS_ID_W = 2, XLEN = 32).
// Change them here if the top is built with wider parameters.
package cva6_ldbuf_pkg;

    localparam int unsigned LDBUF_TRANS_ID_W = 2;
    localparam int unsigned LDBUF_XLEN       = 32;
    localparam int unsigned LDBUF_OFFSET_W   = $clog2(LDBUF_XLEN / 8);

    // Size encodings seen on the alloc port
    localparam logic [1:0] LDBUF_SIZE_BYTE  = 2'd0;
    localparam logic [1:0] LDBUF_SIZE_HALF  = 2'd1;
    localparam logic [1:0] LDBUF_SIZE_WORD  = 2'd2;
    localparam logic [1:0] LDBUF_SIZE_DWORD = 2'd3;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        PEND   = 2'd1,
        KILLED = 2'd2
    } ldbuf_state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE  = LDBUF_SIZE_BYTE,
        SIZE_HALF  = LDBUF_SIZE_HALF,
        SIZE_WORD  = LDBUF_SIZE_WORD,
        SIZE_DWORD = LDBUF_SIZE_DWORD
    } ldbuf_size_e;

    typedef struct packed {
        logic [LDBUF_TRANS_ID_W-1:0] trans_id;
        logic [LDBUF_OFFSET_W-1:0]   offset;
        ldbuf_size_e                 size;
        logic                        sign;
    } ldbuf_entry_t;

endpackage

// File: rtl/cva6_load_buffer_if.sv
// Alloc / response / writeback signal bundle for the load buffer.
// slave modport is the buffer itself; master is the load unit + cache side.
interface cva6_load_buffer_if #(
    parameter int unsigned NR_ENTRIES = 2,
    parameter int unsigned ID_W       = $clog2(NR_ENTRIES),
    parameter int unsigned TRANS_ID_W = 2,
    parameter int unsigned XLEN       = 32
);
    localparam int unsigned OFF_W = $clog2(XLEN / 8);

    logic                  alloc_valid_i;
    logic                  alloc_ready_o;
    logic [TRANS_ID_W-1:0] alloc_trans_id_i;
    logic [OFF_W-1:0]      alloc_offset_i;
    logic [1:0]            alloc_size_i;
    logic                  alloc_sign_i;
    logic [ID_W-1:0]       alloc_id_o;

    logic                  rsp_valid_i;
    logic [ID_W-1:0]       rsp_id_i;
    logic [XLEN-1:0]       rsp_data_i;

    logic                  wb_valid_o;
    logic [TRANS_ID_W-1:0] wb_trans_id_o;
    logic [XLEN-1:0]       wb_data_o;

    modport slave (
        input  alloc_valid_i, alloc_trans_id_i, alloc_offset_i, alloc_size_i, alloc_sign_i,
        output alloc_ready_o, alloc_id_o,
        input  rsp_valid_i, rsp_id_i, rsp_data_i,
        output wb_valid_o, wb_trans_id_o, wb_data_o
    );

    modport master (
        output alloc_valid_i, alloc_trans_id_i, alloc_offset_i, alloc_size_i, alloc_sign_i,
        input  alloc_ready_o, alloc_id_o,
        output rsp_valid_i, rsp_id_i, rsp_data_i,
        input  wb_valid_o, wb_trans_id_o, wb_data_o
    );

endinterface

// File: rtl/cva6_ldbuf_extend.sv
// Load data alignment: shift the raw word down by the byte offset, keep the
// field selected by size and sign- or zero-extend it to XLEN. Purely
// combinational; bytes shifted past the top read as zero.
module cva6_ldbuf_extend
    import cva6_ldbuf_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  data_i,
    input  logic [OFF_W-1:0] offset_i,
    input  ldbuf_size_e      size_i,
    input  logic             sign_i,
    output logic [XLEN-1:0]  data_o
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] word_ext;

    assign shifted = data_i >> {offset_i, 3'b000};

    // A word only needs extending when the datapath is wider than 32 bits
    generate
        if (XLEN > 32) begin : g_word_ext
            assign word_ext = {{(XLEN-32){sign_i & shifted[31]}}, shifted[31:0]};
        end else begin : g_word_full
            assign word_ext = shifted;
        end
    endgenerate

    // Select kept field and extend it
    always_comb begin
        data_o = shifted;
        case (size_i)
            SIZE_BYTE:  data_o = {{(XLEN-8){sign_i & shifted[7]}}, shifted[7:0]};
            SIZE_HALF:  data_o = {{(XLEN-16){sign_i & shifted[15]}}, shifted[15:0]};
            SIZE_WORD:  data_o = word_ext;
            default:    data_o = shifted;
        endcase
    end

endmodule

// File: rtl/cva6_load_buffer.sv
// Outstanding-load tracker between the load unit and scoreboard writeback.
// The buffer index granted at alloc doubles as the cache transaction ID.
// Optional macro CVA6_LDBUF_OUT_REG_EN registers the writeback outputs
// (one cycle latency); by default they are combinational from the response.
module cva6_load_buffer
    import cva6_ldbuf_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 2,
    parameter int unsigned ID_W       = $clog2(NR_ENTRIES),
    parameter int unsigned TRANS_ID_W = LDBUF_TRANS_ID_W,
    parameter int unsigned XLEN       = LDBUF_XLEN
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    output logic                empty_o,
    output logic                err_o,
    cva6_load_buffer_if.slave   bus
);

    localparam int unsigned OFF_W = $clog2(XLEN / 8);

    ldbuf_state_e    state_q [NR_ENTRIES];
    ldbuf_state_e    state_d [NR_ENTRIES];
    ldbuf_entry_t    entry_q [NR_ENTRIES];
    ldbuf_entry_t    entry_d [NR_ENTRIES];
    logic            err_q, err_d;

    logic            free_found;
    logic [ID_W-1:0] free_idx;
    logic            alloc_ready;
    logic            alloc_fire;
    logic            all_free;
    ldbuf_state_e    rsp_state;
    ldbuf_entry_t    rsp_entry;
    logic            wb_fire;
    logic [XLEN-1:0] ext_data;

    // Lowest-index free entry, from registered state only
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = int'(NR_ENTRIES) - 1; i >= 0; i--) begin
            if (state_q[i] == FREE) begin
                free_found = 1'b1;
                free_idx   = ID_W'(i);
            end
        end
    end

    // Empty when every entry is free (killed entries still count as busy)
    always_comb begin
        all_free = 1'b1;
        for (int i = 0; i < int'(NR_ENTRIES); i++) begin
            if (state_q[i] != FREE) all_free = 1'b0;
        end
    end

    assign alloc_ready       = free_found && !flush_i;
    assign alloc_fire        = bus.alloc_valid_i && alloc_ready;
    assign bus.alloc_ready_o = alloc_ready;
    assign bus.alloc_id_o    = free_idx;
    assign empty_o           = all_free;
    assign err_o             = err_q;

    assign rsp_state = state_q[bus.rsp_id_i];
    assign rsp_entry = entry_q[bus.rsp_id_i];
    // A flush in the response cycle kills the writeback as well
    assign wb_fire   = bus.rsp_valid_i && (rsp_state == PEND) && !flush_i;

    cva6_ldbuf_extend #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_extend (
        .data_i   (bus.rsp_data_i),
        .offset_i (OFF_W'(rsp_entry.offset)),
        .size_i   (rsp_entry.size),
        .sign_i   (rsp_entry.sign),
        .data_o   (ext_data)
    );

    // Entry next state: alloc, then flush, then response (response wins on its entry)
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        err_d   = err_q;

        if (alloc_fire) begin
            state_d[free_idx]          = PEND;
            entry_d[free_idx].trans_id = LDBUF_TRANS_ID_W'(bus.alloc_trans_id_i);
            entry_d[free_idx].offset   = LDBUF_OFFSET_W'(bus.alloc_offset_i);
            entry_d[free_idx].size     = ldbuf_size_e'(bus.alloc_size_i);
            entry_d[free_idx].sign     = bus.alloc_sign_i;
        end

        if (flush_i) begin
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                if (state_q[i] == PEND) state_d[i] = KILLED;
            end
        end

        if (bus.rsp_valid_i) begin
            case (rsp_state)
                PEND, KILLED: state_d[bus.rsp_id_i] = FREE;
                default:      err_d = 1'b1;
            endcase
        end
    end

    // Entry state and metadata registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                state_q[i] <= FREE;
                entry_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                state_q[i] <= state_d[i];
                entry_q[i] <= entry_d[i];
            end
            err_q <= err_d;
        end
    end

`ifdef CVA6_LDBUF_OUT_REG_EN
    logic                  wb_valid_q, wb_valid_d;
    logic [TRANS_ID_W-1:0] wb_trans_id_q, wb_trans_id_d;
    logic [XLEN-1:0]       wb_data_q, wb_data_d;

    // Writeback register inputs; suppressed writebacks load zeros
    always_comb begin
        wb_valid_d    = wb_fire;
        wb_trans_id_d = wb_fire ? TRANS_ID_W'(rsp_entry.trans_id) : '0;
        wb_data_d     = wb_fire ? ext_data : '0;
    end

    // Writeback output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_valid_q    <= 1'b0;
            wb_trans_id_q <= '0;
            wb_data_q     <= '0;
        end else begin
            wb_valid_q    <= wb_valid_d;
            wb_trans_id_q <= wb_trans_id_d;
            wb_data_q     <= wb_data_d;
        end
    end

    assign bus.wb_valid_o    = wb_valid_q;
    assign bus.wb_trans_id_o = wb_trans_id_q;
    assign bus.wb_data_o     = wb_data_q;
`else
    assign bus.wb_valid_o    = wb_fire;
    assign bus.wb_trans_id_o = wb_fire ? TRANS_ID_W'(rsp_entry.trans_id) : '0;
    assign bus.wb_data_o     = wb_fire ? ext_data : '0;
`endif

endmodule

// File: tb/tb_cva6_load_buffer.sv
// Directed bench for cva6_load_buffer with a writeback scoreboard.
// Works in both writeback configurations (CVA6_LDBUF_OUT_REG_EN on or off).
module tb_cva6_load_buffer;

    localparam int unsigned NR_ENTRIES = 2;
    localparam int unsigned ID_W       = 1;
    localparam int unsigned TRANS_ID_W = 2;
    localparam int unsigned XLEN       = 32;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    logic flush_i;
    logic empty_o;
    logic err_o;

    int total = 0;
    int bad   = 0;

    logic [TRANS_ID_W+XLEN-1:0] exp_q [$];

    cva6_load_buffer_if #(
        .NR_ENTRIES (NR_ENTRIES),
        .ID_W       (ID_W),
        .TRANS_ID_W (TRANS_ID_W),
        .XLEN       (XLEN)
    ) bus ();

    cva6_load_buffer #(
        .NR_ENTRIES (NR_ENTRIES),
        .ID_W       (ID_W),
        .TRANS_ID_W (TRANS_ID_W),
        .XLEN       (XLEN)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .empty_o (empty_o),
        .err_o   (err_o),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic alloc(input logic [1:0] tid, input logic [1:0] off,
                         input logic [1:0] size, input logic sign);
        bus.alloc_valid_i    = 1'b1;
        bus.alloc_trans_id_i = tid;
        bus.alloc_offset_i   = off;
        bus.alloc_size_i     = size;
        bus.alloc_sign_i     = sign;
    endtask

    task automatic rsp(input logic id, input logic [31:0] data);
        bus.rsp_valid_i = 1'b1;
        bus.rsp_id_i    = id;
        bus.rsp_data_i  = data;
    endtask

    // Scoreboard: every writeback must match the oldest expected entry
    always @(negedge clk_i) begin
        if (rst_ni && bus.wb_valid_o) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_wb: observed tid=%0d data=%08h expected none",
                       bus.wb_trans_id_o, bus.wb_data_o);
            end
            if (exp_q.size() != 0) begin
                logic [TRANS_ID_W+XLEN-1:0] e;
                e = exp_q.pop_front();
                total++;
                assert ({bus.wb_trans_id_o, bus.wb_data_o} === e) else begin
                    bad++;
                    $error("FAIL wb: observed tid=%0d data=%08h expected tid=%0d data=%08h",
                           bus.wb_trans_id_o, bus.wb_data_o, e[XLEN+:TRANS_ID_W], e[XLEN-1:0]);
                end
                $display("wb tid=%0d data=%08h", bus.wb_trans_id_o, bus.wb_data_o);
            end
        end
    end

    initial begin
        flush_i              = 1'b0;
        bus.alloc_valid_i    = 1'b0;
        bus.alloc_trans_id_i = '0;
        bus.alloc_offset_i   = '0;
        bus.alloc_size_i     = '0;
        bus.alloc_sign_i     = 1'b0;
        bus.rsp_valid_i      = 1'b0;
        bus.rsp_id_i         = '0;
        bus.rsp_data_i       = '0;

        // Reset state
        repeat (2) @(posedge clk_i);
        #3;
        chk("rst_empty", empty_o, 1);
        chk("rst_err", err_o, 0);
        chk("rst_wb_valid", bus.wb_valid_o, 0);
        chk("rst_ready", bus.alloc_ready_o, 1);
        tick();
        rst_ni = 1'b1;
        tick();

        // Two allocs, responses in reverse order
        alloc(2'd1, 2'd0, 2'd2, 1'b0);
        #2;
        chk("t1_ready", bus.alloc_ready_o, 1);
        chk("t1_id0", bus.alloc_id_o, 0);
        tick();
        alloc(2'd3, 2'd0, 2'd2, 1'b0);
        #2;
        chk("t1_id1", bus.alloc_id_o, 1);
        tick();
        bus.alloc_valid_i = 1'b0;
        #2;
        chk("t1_full_ready", bus.alloc_ready_o, 0);
        chk("t1_not_empty", empty_o, 0);
        rsp(1'b1, 32'h1234_5678);
        exp_q.push_back({2'd3, 32'h1234_5678});
        tick();
        rsp(1'b0, 32'hCAFE_F00D);
        exp_q.push_back({2'd1, 32'hCAFE_F00D});
        tick();
        bus.rsp_valid_i = 1'b0;
        tick();
        #2;
        chk("t1_empty", empty_o, 1);

        // Byte and half extraction with sign/zero extension
        alloc(2'd2, 2'd3, 2'd0, 1'b1);
        tick();
        alloc(2'd0, 2'd3, 2'd0, 1'b0);
        tick();
        bus.alloc_valid_i = 1'b0;
        rsp(1'b0, 32'h80AA_BBCC);
        exp_q.push_back({2'd2, 32'hFFFF_FF80});
        tick();
        rsp(1'b1, 32'h80AA_BBCC);
        exp_q.push_back({2'd0, 32'h0000_0080});
        tick();
        bus.rsp_valid_i = 1'b0;
        alloc(2'd1, 2'd2, 2'd1, 1'b1);
        tick();
        alloc(2'd2, 2'd1, 2'd0, 1'b1);
        tick();
        bus.alloc_valid_i = 1'b0;
        rsp(1'b0, 32'h8001_1234);
        exp_q.push_back({2'd1, 32'hFFFF_8001});
        tick();
        rsp(1'b1, 32'h0000_7F00);
        exp_q.push_back({2'd2, 32'h0000_007F});
        tick();
        bus.rsp_valid_i = 1'b0;
        tick();

        // Full buffer: response and alloc together give no same-cycle grant
        alloc(2'd1, 2'd0, 2'd2, 1'b0);
        tick();
        alloc(2'd2, 2'd0, 2'd2, 1'b0);
        tick();
        alloc(2'd3, 2'd0, 2'd2, 1'b0);
        rsp(1'b0, 32'h1111_1111);
        exp_q.push_back({2'd1, 32'h1111_1111});
        #2;
        chk("t3_no_bypass", bus.alloc_ready_o, 0);
        tick();
        bus.rsp_valid_i = 1'b0;
        #2;
        chk("t3_ready_next", bus.alloc_ready_o, 1);
        chk("t3_id_next", bus.alloc_id_o, 0);
        tick();
        bus.alloc_valid_i = 1'b0;
        rsp(1'b1, 32'h2222_2222);
        exp_q.push_back({2'd2, 32'h2222_2222});
        tick();
        rsp(1'b0, 32'h3333_3333);
        exp_q.push_back({2'd3, 32'h3333_3333});
        tick();
        bus.rsp_valid_i = 1'b0;
        tick();

        // Flush: blocks alloc, kills pending entries, late responses dropped
        alloc(2'd1, 2'd0, 2'd2, 1'b0);
        tick();
        alloc(2'd2, 2'd0, 2'd2, 1'b0);
        flush_i = 1'b1;
        #2;
        chk("t4_flush_ready", bus.alloc_ready_o, 0);
        tick();
        flush_i = 1'b0;
        #2;
        chk("t4_killed_busy_id", bus.alloc_id_o, 1);
        tick();
        bus.alloc_valid_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #2;
        chk("t4_killed_not_empty", empty_o, 0);
        rsp(1'b0, 32'hDEAD_0000);
        tick();
        rsp(1'b1, 32'hDEAD_0001);
        #2;
        chk("t4_one_killed", empty_o, 0);
        tick();
        bus.rsp_valid_i = 1'b0;
        #2;
        chk("t4_empty", empty_o, 1);
        alloc(2'd3, 2'd0, 2'd2, 1'b0);
        tick();
        bus.alloc_valid_i = 1'b0;
        flush_i = 1'b1;
        rsp(1'b0, 32'hDEAD_0002);
        tick();
        flush_i = 1'b0;
        bus.rsp_valid_i = 1'b0;
        tick();
        #2;
        chk("t4_flush_rsp_empty", empty_o, 1);
        chk("t4_no_err", err_o, 0);

        // Response to a free entry: sticky error, no writeback
        rsp(1'b1, 32'hBAD0_BAD0);
        tick();
        bus.rsp_valid_i = 1'b0;
        #2;
        chk("t5_err_set", err_o, 1);
        repeat (3) tick();
        chk("t5_err_sticky", err_o, 1);

        // Asynchronous reset mid-stream with two loads pending
        alloc(2'd1, 2'd0, 2'd2, 1'b0);
        tick();
        alloc(2'd2, 2'd0, 2'd2, 1'b0);
        tick();
        bus.alloc_valid_i = 1'b0;
        #1;
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_empty", empty_o, 1);
        chk("t6_rst_err", err_o, 0);
        chk("t6_rst_wb_valid", bus.wb_valid_o, 0);
        chk("t6_rst_wb_tid", bus.wb_trans_id_o, 0);
        chk("t6_rst_wb_data", bus.wb_data_o, 0);
        tick();
        rst_ni = 1'b1;
        rsp(1'b0, 32'h5555_5555);
        tick();
        bus.rsp_valid_i = 1'b0;
        #2;
        chk("t6_stale_err", err_o, 1);
        chk("t6_stale_empty", empty_o, 1);
        repeat (2) tick();

        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cva6_load_buffer.md
# cva6_load_buffer

Tracks outstanding data-cache loads between the load unit's request stage and the scoreboard writeback port. Each accepted load is assigned a free buffer index, which doubles as the cache transaction ID, and stores its scoreboard transaction ID, byte offset, size and sign flag. When the cache response arrives the block aligns and extends the data and presents one writeback per response. A flush marks in-flight entries as killed so that their late responses are silently discarded.

## Interface
- NR_ENTRIES, 2: number of outstanding loads; power of two, ≥2.
- ID_W, $clog2(NR_ENTRIES): cache transaction-ID width.
- TRANS_ID_W, 2: scoreboard transaction-ID width.
- XLEN, 32: data width; 32 or 64.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  kill all in-flight loads.
- alloc_valid_i  in  1  load request wants an entry.
- alloc_ready_o  out  1  entry available.
- alloc_trans_id_i  in  TRANS_ID_W  scoreboard ID.
- alloc_offset_i  in  $clog2(XLEN/8)  byte offset in word.
- alloc_size_i  in  2  0 byte, 1 half, 2 word, 3 dword (XLEN=64 only).
- alloc_sign_i  in  1  sign-extend result.
- alloc_id_o  out  ID_W  index granted; valid when alloc_valid_i && alloc_ready_o.
- rsp_valid_i  in  1  cache response.
- rsp_id_i  in  ID_W  response transaction ID.
- rsp_data_i  in  XLEN  raw response word.
- wb_valid_o  out  1  writeback strobe; no backpressure.
- wb_trans_id_o  out  TRANS_ID_W  scoreboard ID.
- wb_data_o  out  XLEN  aligned, extended data.
- empty_o  out  1  no valid or killed entries.
- err_o  out  1  sticky: response hit a free entry.

## Operation
- Per-entry state: FREE, PEND, KILLED. All entries reset to FREE.
- alloc_ready_o = any FREE entry && !flush_i. Readiness comes from registered state only; there is no same-cycle bypass from a freeing response.
- alloc_id_o = lowest-index FREE entry. On handshake that entry goes FREE→PEND and captures the metadata.
- On rsp_valid_i, the entry at rsp_id_i transitions as follows:
  - PEND → FREE, producing a writeback.
  - KILLED → FREE, with no writeback.
  - FREE → no state change; sets err_o, which is cleared only by reset.
- flush_i: every PEND entry becomes KILLED, and no alloc is accepted that cycle. If a response arrives in the same cycle, that entry goes to FREE with no writeback. KILLED entries stay KILLED.
- Response and alloc in the same cycle are both processed. If they target different entries, both take effect. Identical IDs cannot occur, because alloc only picks entries that are FREE in registered state.
- Data path:
  - shifted = rsp_data_i >> (offset×8).
  - Keep the low 8/16/32/64 bits per size.
  - If sign is set, sign-extend from the MSB of the kept field; otherwise zero-fill.
  - Bytes shifted past the top are zero.
  - Alignment is the requester's responsibility; no check is made.
- empty_o = all entries FREE.

## Timing
- Allocation: combinational grant, with state updated at the next edge.
- Writeback latency depends on CVA6_LDBUF_OUT_REG_EN (see Configuration).
- Throughput: one alloc and one response per cycle. With NR_ENTRIES=2 and a 1-cycle cache, back-to-back loads are sustained.
- Reset mid-operation: all entries go to FREE, and wb_valid_o, err_o, wb_trans_id_o and wb_data_o are all 0. Responses arriving after reset for pre-reset IDs set err_o.

## Configuration
- CVA6_LDBUF_OUT_REG_EN defined: the writeback outputs are registered. wb_valid_o asserts the cycle after the response. A flush in the response cycle still suppresses the writeback, because suppression is evaluated before the register.
- CVA6_LDBUF_OUT_REG_EN undefined: the writeback outputs are combinational from the rsp_* inputs and entry state, with zero latency.

## Structure
- Package cva6_ldbuf_pkg holds:
  - ldbuf_state_e {FREE, PEND, KILLED}.
  - ldbuf_size_e.
  - ldbuf_entry_t {trans_id, offset, size, sign}.
  - Size-encoding constants.
- One sub-module, cva6_ldbuf_extend: purely combinational shift, mask and sign/zero extension, shared by both configurations.

## Test plan
- Two allocs (trans 1, trans 3) followed by responses in reverse order, ID1 then ID0 → writebacks are trans 3 then trans 1, with alloc_id_o 0 then 1.
- Size byte, offset 3, sign=1, rsp_data 0x80AA_BBCC → wb_data 0xFFFF_FF80. With sign=0 → 0x0000_0080.
- Fill both entries → alloc_ready_o=0. A response on ID0 combined with alloc_valid_i in the same cycle → no grant that cycle, and alloc_id_o=0 granted on the next cycle.
- flush_i with both entries PEND, then responses on ID0 and ID1 → no wb_valid_o, and empty_o=1 after the second response.
- Response on ID1 while it is FREE → err_o=1 and stays high until rst_ni low; no writeback.
- Assert rst_ni low mid-stream with 2 pending → empty_o=1 and all outputs 0 immediately, without waiting for a clock edge.
